// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer.
//   INSTR_W     : width of one encoded CPU instruction
//   DEPTH_DEF   : default instruction queue depth (power of two)
//   TIMEOUT_DEF : default watchdog limit, in cycles, from cpu_s to cpu_w high
//   state_e     : sequencer FSM state encoding
package seq_pkg;

    localparam int INSTR_W     = 16;
    localparam int DEPTH_DEF   = 8;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_LOW  = 3'd3,
        ST_WAIT_HIGH = 3'd4,
        ST_ERROR     = 3'd5
    } state_e;

endpackage

// File: rtl/instr_fifo.sv
// Instruction queue: DEPTH x W circular buffer with a combinational head read.
// Ports:
//   clk      : clock
//   reset_i  : synchronous active-high reset (flushes pointers and count)
//   push_i   : write wdata_i at the tail (ignored when full)
//   wdata_i  : data to push
//   pop_i    : advance the head (ignored when empty)
//   rdata_o  : current head entry
//   full_o   : count == DEPTH
//   empty_o  : count == 0
//   count_o  : occupancy, 0..DEPTH
module instr_fifo
    import seq_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int W     = INSTR_W
) (
    input  logic                     clk,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     pop_i,
    output logic [W-1:0]             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Head is read combinationally so it can be captured on the same edge
    // that moves the sequencer into LOAD.
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: queues host instructions and issues them one at a
// time to a CPU using a load strobe, a start strobe and the CPU's wait flag,
// with a watchdog that parks the block in an absorbing ERROR state.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   host_valid  : host offers host_instr
//   host_instr  : encoded instruction from the host
//   host_ready  : queue accepts (not full and not in ERROR)
//   enable      : permits issue of queued instructions
//   cpu_w       : CPU waiting/idle flag
//   cpu_in      : instruction presented to the CPU (held between issues)
//   cpu_load    : one-cycle instruction-register load strobe
//   cpu_s       : one-cycle CPU start strobe
//   count       : queue occupancy
//   busy        : FSM is neither IDLE nor ERROR
//   retire      : one-cycle pulse when an instruction completes
//   retired     : wrapping count of completed instructions
//   err         : sticky watchdog timeout flag
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    host_valid,
    input  logic [INSTR_W-1:0]      host_instr,
    output logic                    host_ready,
    input  logic                    enable,
    input  logic                    cpu_w,
    output logic [INSTR_W-1:0]      cpu_in,
    output logic                    cpu_load,
    output logic                    cpu_s,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    busy,
    output logic                    retire,
    output logic [15:0]             retired,
    output logic                    err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_e               state_q, state_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic [WD_W-1:0]      wd_inc;
    logic [INSTR_W-1:0]   cpu_in_q, cpu_in_d;
    logic                 retire_q, retire_d;
    logic [15:0]          retired_q, retired_d;
    logic                 err_q, err_d;

    logic [INSTR_W-1:0]   fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;

    // Readiness looks only at the registered fullness, so a pop in the same
    // cycle never opens a slot early.
    assign host_ready = !fifo_full && (state_q != ST_ERROR);
    assign push       = host_valid && host_ready;
    assign pop        = (state_q == ST_LOAD);

    instr_fifo #(
        .DEPTH (DEPTH),
        .W     (INSTR_W)
    ) u_fifo (
        .clk     (clk),
        .reset_i (reset),
        .push_i  (push),
        .wdata_i (host_instr),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

    assign wd_inc = wd_q + WD_W'(1);

    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        cpu_in_d  = cpu_in_q;
        retire_d  = 1'b0;
        retired_d = retired_q;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                // Capture the head on entry so cpu_in is already valid
                // during the LOAD cycle; the head itself pops at LOAD's end.
                if (enable && !fifo_empty && cpu_w) begin
                    state_d  = ST_LOAD;
                    cpu_in_d = fifo_head;
                end
            end
            ST_LOAD: begin
                state_d = ST_START;
            end
            ST_START: begin
                wd_d    = '0;
                state_d = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                wd_d = wd_inc;
                if (wd_inc >= WD_W'(TIMEOUT)) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                end else if (!cpu_w) begin
                    state_d = ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                // Completion on the last permitted cycle wins over timeout.
                if (cpu_w) begin
                    state_d   = ST_IDLE;
                    retire_d  = 1'b1;
                    retired_d = retired_q + 16'd1;
                end else begin
                    wd_d = wd_inc;
                    if (wd_inc >= WD_W'(TIMEOUT)) begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            wd_q      <= '0;
            cpu_in_q  <= '0;
            retire_q  <= 1'b0;
            retired_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            cpu_in_q  <= cpu_in_d;
            retire_q  <= retire_d;
            retired_q <= retired_d;
            err_q     <= err_d;
        end
    end

    assign cpu_in   = cpu_in_q;
    assign cpu_load = (state_q == ST_LOAD);
    assign cpu_s    = (state_q == ST_START);
    assign busy     = (state_q != ST_IDLE) && (state_q != ST_ERROR);
    assign retire   = retire_q;
    assign retired  = retired_q;
    assign err      = err_q;

endmodule
